// File: rtl/program_counter_seq.sv
// Program counter with stall-tolerant redirect latch, permanent halt and PC write counter.
// Latency: one cycle from inputs to registered outputs; updatePC=0 stalls the PC and parks redirects in HOLD.
// Build option PC_ALIGN_CHECK_EN sends misaligned redirects to TRAP_PC and pulses align_fault.
module program_counter_seq #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     INC      = 4,
  parameter int unsigned     CNT_W    = 32,
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'('h80)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             updatePC,
  input  logic [1:0]       pcSel,
  input  logic [PC_W-1:0]  branch,
  input  logic [PC_W-1:0]  jump,
  input  logic [PC_W-1:0]  rdat1,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             pending,
  output logic             halted,
  output logic [CNT_W-1:0] upd_cnt,
  output logic             align_fault
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_HOLD   = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t           state_q, state_n;
  logic [PC_W-1:0]  pc_q, pc_n;
  logic [PC_W-1:0]  pend_q, pend_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             pending_q, halted_q, af_q, af_n;

  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  seq_pc;
  logic [PC_W-1:0]  redir_val;
  logic             pc_wr;
  logic             redirect;
  logic             align_hit;

  assign seq_pc = pc_q + PC_W'(INC);

  always_comb begin
    tgt = rdat1;
    case (pcSel)
      2'b01:   tgt = branch;
      2'b10:   tgt = jump;
      default: tgt = rdat1;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    pend_n    = pend_q;
    pc_n      = pc_q;
    cnt_n     = cnt_q;
    af_n      = 1'b0;
    pc_wr     = 1'b0;
    redirect  = 1'b0;
    redir_val = tgt;
    align_hit = 1'b0;

    case (state_q)
      S_RUN: begin
        if (halt) begin
          state_n = S_HALTED;
          pend_n  = '0;
        end else if (updatePC) begin
          pc_wr    = 1'b1;
          redirect = (pcSel != 2'b00);
        end else if (pcSel != 2'b00) begin
          pend_n  = tgt;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (halt) begin
          state_n = S_HALTED;
          pend_n  = '0;
        end else if (updatePC) begin
          // A fresh redirect in the release cycle beats the parked one.
          pc_wr     = 1'b1;
          redirect  = 1'b1;
          redir_val = (pcSel != 2'b00) ? tgt : pend_q;
          pend_n    = '0;
          state_n   = S_RUN;
        end else if (pcSel != 2'b00) begin
          pend_n = tgt;
        end
      end
      S_HALTED: begin
        state_n = S_HALTED;
      end
      default: begin
        state_n = S_RUN;
        pend_n  = '0;
      end
    endcase

`ifdef PC_ALIGN_CHECK_EN
    align_hit = pc_wr && redirect && (redir_val[1:0] != 2'b00);
`endif

    if (pc_wr) begin
      cnt_n = cnt_q + 1'b1;
      af_n  = align_hit;
      if (!redirect)
        pc_n = seq_pc;
      else if (align_hit)
        pc_n = TRAP_PC;
      else
        pc_n = redir_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      halted_q  <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      pend_q    <= pend_n;
      cnt_q     <= cnt_n;
      pending_q <= (state_n == S_HOLD);
      halted_q  <= (state_n == S_HALTED);
      af_q      <= af_n;
    end
  end

  assign pc          = pc_q;
  assign pending     = pending_q;
  assign halted      = halted_q;
  assign upd_cnt     = cnt_q;
  assign align_fault = af_q;

endmodule

// File: tb/tb_program_counter_seq.sv
// Bench for program_counter_seq: directed scenarios then randomized traffic against a behavioural model.
module tb_program_counter_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        updatePC;
  logic [1:0]  pcSel;
  logic [31:0] branch, jump, rdat1;
  logic        halt;
  logic [31:0] pc;
  logic        pending, halted, align_fault;
  logic [31:0] upd_cnt;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // behavioural model
  logic [31:0] m_pc, m_pend, m_cnt;
  bit          m_hold, m_halted, m_af;

  program_counter_seq dut (
    .CLK(CLK), .RST(RST), .updatePC(updatePC), .pcSel(pcSel),
    .branch(branch), .jump(jump), .rdat1(rdat1), .halt(halt),
    .pc(pc), .pending(pending), .halted(halted),
    .upd_cnt(upd_cnt), .align_fault(align_fault)
  );

  always #5 CLK = ~CLK;

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] tgt, val;
    bit          redir;
    tgt  = (pcSel == 2'd1) ? branch : (pcSel == 2'd2) ? jump : rdat1;
    m_af = 1'b0;
    if (RST) begin
      m_pc = 32'h0; m_pend = 32'h0; m_cnt = 32'h0; m_hold = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (halt) begin
      m_halted = 1'b1; m_hold = 1'b0; m_pend = 32'h0;
    end else if (updatePC) begin
      if (pcSel != 2'd0)  begin val = tgt;        redir = 1'b1; end
      else if (m_hold)    begin val = m_pend;     redir = 1'b1; end
      else                begin val = m_pc + 32'd4; redir = 1'b0; end
      if (ALIGN && redir && (val % 4 != 0)) begin
        val  = 32'h80;
        m_af = 1'b1;
      end
      m_pc   = val;
      m_cnt  = m_cnt + 32'd1;
      m_hold = 1'b0;
      m_pend = 32'h0;
    end else if (pcSel != 2'd0) begin
      m_pend = tgt;
      m_hold = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; updatePC = 1'b1; pcSel = 2'd3; rdat1 = 32'h1234; halt = 1'b0;
    branch = 32'h0; jump = 32'h0;
    tick(); tick();
    n_vec++; if (pc !== 32'h0)          begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
    n_vec++; if (pending !== 1'b0)      begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
    n_vec++; if (halted !== 1'b0)       begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_vec++; if (upd_cnt !== 32'h0)     begin n_err++; $display("FAIL reset_cnt got %0d want 0", upd_cnt); end
    n_vec++; if (align_fault !== 1'b0)  begin n_err++; $display("FAIL reset_af got %b want 0", align_fault); end
  endtask

  task automatic test_sequential();
    RST = 1'b0; updatePC = 1'b1; pcSel = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (pc !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc step %0d got %h want %h", i, pc, 32'(4 * i)); end
    end
    n_vec++; if (upd_cnt !== 32'd3) begin n_err++; $display("FAIL seq_cnt got %0d want 3", upd_cnt); end
  endtask

  task automatic test_wrap();
    updatePC = 1'b1; pcSel = 2'd3; rdat1 = 32'hFFFF_FFFC;
    tick();
    n_vec++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_load got %h want fffffffc", pc); end
    pcSel = 2'd0;
    tick();
    n_vec++; if (pc !== 32'h0)   begin n_err++; $display("FAIL wrap_pc got %h want 0", pc); end
    n_vec++; if (upd_cnt !== 32'd5) begin n_err++; $display("FAIL wrap_cnt got %0d want 5", upd_cnt); end
  endtask

  task automatic test_redirect_stall();
    updatePC = 1'b0; pcSel = 2'd2; jump = 32'h400;
    tick();
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL hold1_pending got %b want 1", pending); end
    n_vec++; if (pc !== 32'h0)     begin n_err++; $display("FAIL hold1_pc got %h want 0", pc); end
    pcSel = 2'd1; branch = 32'h500;
    tick();
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL hold2_pending got %b want 1", pending); end
    n_vec++; if (pc !== 32'h0)     begin n_err++; $display("FAIL hold2_pc got %h want 0", pc); end
    updatePC = 1'b1; pcSel = 2'd0;
    tick();
    n_vec++; if (pc !== 32'h500)   begin n_err++; $display("FAIL release_pc got %h want 500", pc); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL release_pending got %b want 0", pending); end
    n_vec++; if (upd_cnt !== 32'd6) begin n_err++; $display("FAIL release_cnt got %0d want 6", upd_cnt); end
  endtask

  task automatic test_halt();
    halt = 1'b1; updatePC = 1'b1; pcSel = 2'd3; rdat1 = 32'h40;
    tick();
    n_vec++; if (pc !== 32'h500)   begin n_err++; $display("FAIL halt_pc got %h want 500", pc); end
    n_vec++; if (halted !== 1'b1)  begin n_err++; $display("FAIL halt_flag got %b want 1", halted); end
    for (int i = 0; i < 8; i++) begin
      halt = 1'($urandom); updatePC = 1'($urandom); pcSel = 2'($urandom);
      branch = $urandom; jump = $urandom; rdat1 = $urandom;
      tick();
    end
    n_vec++; if (pc !== 32'h500)   begin n_err++; $display("FAIL halted_pc got %h want 500", pc); end
    n_vec++; if (upd_cnt !== 32'd6) begin n_err++; $display("FAIL halted_cnt got %0d want 6", upd_cnt); end
    n_vec++; if (halted !== 1'b1 || pending !== 1'b0)
      begin n_err++; $display("FAIL halted_flags got halted=%b pending=%b want 1/0", halted, pending); end
    RST = 1'b1; halt = 1'b0;
    tick();
    RST = 1'b0;
    n_vec++; if (pc !== 32'h0)     begin n_err++; $display("FAIL unhalt_pc got %h want 0", pc); end
    n_vec++; if (halted !== 1'b0)  begin n_err++; $display("FAIL unhalt_flag got %b want 0", halted); end
  endtask

  task automatic test_align();
    logic [31:0] want;
    updatePC = 1'b1; pcSel = 2'd3; rdat1 = 32'h42; halt = 1'b0;
    tick();
    want = ALIGN ? 32'h80 : 32'h42;
    n_vec++; if (pc !== want)          begin n_err++; $display("FAIL align_pc got %h want %h", pc, want); end
    n_vec++; if (align_fault !== ALIGN) begin n_err++; $display("FAIL align_af got %b want %b", align_fault, ALIGN); end
    n_vec++; if (upd_cnt !== 32'd1)    begin n_err++; $display("FAIL align_cnt got %0d want 1", upd_cnt); end
    updatePC = 1'b0; pcSel = 2'd1; branch = 32'h106;
    tick();
    n_vec++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL align_pulse got %b want 0", align_fault); end
    updatePC = 1'b1; pcSel = 2'd0;
    tick();
    want = ALIGN ? 32'h80 : 32'h106;
    n_vec++; if (pc !== want)          begin n_err++; $display("FAIL align_pend_pc got %h want %h", pc, want); end
    n_vec++; if (align_fault !== ALIGN) begin n_err++; $display("FAIL align_pend_af got %b want %b", align_fault, ALIGN); end
  endtask

  task automatic test_reset_in_hold();
    updatePC = 1'b0; pcSel = 2'd2; jump = 32'h800;
    tick();
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL rsthold_pending got %b want 1", pending); end
    RST = 1'b1; pcSel = 2'd0;
    tick();
    RST = 1'b0;
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL rsthold_clear got %b want 0", pending); end
    n_vec++; if (pc !== 32'h0)     begin n_err++; $display("FAIL rsthold_pc got %h want 0", pc); end
    updatePC = 1'b1;
    tick();
    n_vec++; if (pc !== 32'h4)     begin n_err++; $display("FAIL rsthold_next got %h want 4", pc); end
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RST      = ($urandom_range(0, 40) == 0);
      halt     = ($urandom_range(0, 60) == 0);
      updatePC = ($urandom_range(0, 2) != 0);
      pcSel    = 2'($urandom);
      branch   = rnd_tgt(); jump = rnd_tgt(); rdat1 = rnd_tgt();
      tick();
      n_vec++;
      if (pc !== m_pc || pending !== m_hold || halted !== m_halted ||
          upd_cnt !== m_cnt || align_fault !== m_af) begin
        n_err++;
        $display("FAIL random cycle %0d got pc=%h pend=%b halt=%b cnt=%0d af=%b want pc=%h pend=%b halt=%b cnt=%0d af=%b",
                 i, pc, pending, halted, upd_cnt, align_fault, m_pc, m_hold, m_halted, m_cnt, m_af);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_stall();
    test_halt();
    test_align();
    test_reset_in_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
